uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART transmitter among NUM_REQ one-shot requesters, one byte at a time, round-robin.
// Latency: req_start at t -> req_busy at t+1 -> uart_tx_start at t+2 when the arbiter is idle.
// Backpressure: each requester holds one byte; req_busy stays high until that byte is sent, and a strobe while busy is dropped and flagged.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_start/req_data/req_busy    per-requester UART-lookalike interface (byte i at [i*DATA_W +: DATA_W])
//   uart_tx_data/start/busy        towards the real uart_tx
//   grant_id, active               current owner of the UART, byte in flight
//   drop_err, drop_clr             sticky per-requester drop flags and their clear
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int ACK_TIMEOUT = 15,
   localparam int ID_W       = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(ACK_TIMEOUT + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_start,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_busy,
   output logic [DATA_W-1:0]         uart_tx_data,
   output logic                      uart_tx_start,
   input  logic                      uart_tx_busy,
   output logic [ID_W-1:0]           grant_id,
   output logic                      active,
   output logic [NUM_REQ-1:0]        drop_err,
   input  logic                      drop_clr
);

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_WAIT_ACK,
      ARB_WAIT_DONE
   } arb_state_t;

   arb_state_t          state;
   logic [NUM_REQ-1:0]  pending;
   logic [DATA_W-1:0]   hold [NUM_REQ];
   logic [ID_W-1:0]     rr_ptr;
   logic [CNT_W-1:0]    ack_cnt;

   logic                complete;
   logic [NUM_REQ-1:0]  clr_vec;
   logic [NUM_REQ-1:0]  accept;
   logic [NUM_REQ-1:0]  drop;
   logic                win_vld;
   logic [ID_W-1:0]     win_id;

   assign req_busy = pending;

   // The byte in flight finishes either on the falling edge of uart_tx_busy,
   // or when the UART never acknowledged the start within ACK_TIMEOUT cycles.
   always_comb begin
      complete = 1'b0;
      case (state)
         ARB_WAIT_ACK:  complete = !uart_tx_busy && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
         ARB_WAIT_DONE: complete = !uart_tx_busy;
         default:       complete = 1'b0;
      endcase
   end

   // A strobe landing in the same cycle its requester's byte completes is
   // accepted, so a requester chasing its own busy flag never loses a byte.
   always_comb begin
      clr_vec = '0;
      if (complete) clr_vec[grant_id] = 1'b1;
      accept = req_start & (~pending | clr_vec);
      drop   = req_start & pending & ~clr_vec;
   end

   // Round-robin scan starting just after the last owner. Iterating from the
   // farthest offset down lets the nearest pending requester win.
   always_comb begin
      logic [ID_W-1:0] idx;
      win_vld = 1'b0;
      win_id  = '0;
      idx     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (pending[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
   end

   // Capture: one holding byte per requester, never overwritten while pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         drop_err <= '0;
         for (int i = 0; i < NUM_REQ; i++) hold[i] <= '0;
      end else begin
         pending  <= (pending & ~clr_vec) | accept;
         // A drop in the same cycle as drop_clr keeps its flag.
         drop_err <= (drop_err & ~{NUM_REQ{drop_clr}}) | drop;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) hold[i] <= req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Grant FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ARB_IDLE;
         rr_ptr        <= ID_W'(NUM_REQ - 1);
         grant_id      <= '0;
         uart_tx_data  <= '0;
         uart_tx_start <= 1'b0;
         active        <= 1'b0;
         ack_cnt       <= '0;
      end else begin
         uart_tx_start <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (win_vld) begin
                  grant_id      <= win_id;
                  uart_tx_data  <= hold[win_id];
                  uart_tx_start <= 1'b1;
                  active        <= 1'b1;
                  ack_cnt       <= '0;
                  state         <= ARB_WAIT_ACK;
               end
            end
            ARB_WAIT_ACK: begin
               if (uart_tx_busy) begin
                  state <= ARB_WAIT_DONE;
               end else if (complete) begin
                  rr_ptr <= grant_id;
                  active <= 1'b0;
                  state  <= ARB_IDLE;
               end else begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
            ARB_WAIT_DONE: begin
               if (complete) begin
                  rr_ptr <= grant_id;
                  active <= 1'b0;
                  state  <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: randomized and directed bench for uart_tx_arbiter with a scoreboard of expected UART bytes.
// Latency: stimulus pushes expected (owner, byte) entries; a monitor pops one per uart_tx_start.
// Backpressure: a small UART stand-in drives uart_tx_busy (normal, silent-timeout or manual).
module tb_uart_tx_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int DATA_W      = 8;
   localparam int ACK_TIMEOUT = 15;
   localparam int ID_W        = 2;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic [NUM_REQ-1:0]        req_start = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]        req_busy;
   logic [DATA_W-1:0]         uart_tx_data;
   logic                      uart_tx_start;
   logic                      uart_tx_busy = 1'b0;
   logic [ID_W-1:0]           grant_id;
   logic                      active;
   logic [NUM_REQ-1:0]        drop_err;
   logic                      drop_clr = 1'b0;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_start(req_start), .req_data(req_data),
      .req_busy(req_busy), .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
      .uart_tx_busy(uart_tx_busy), .grant_id(grant_id), .active(active),
      .drop_err(drop_err), .drop_clr(drop_clr)
   );

   always #5 clk = ~clk;

   typedef struct { int id; logic [7:0] dat; } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int uart_mode = 0;            // 0 manual, 1 normal UART, 2 UART never answers
   int model_rr = NUM_REQ - 1;   // last owner in the reference model
   int start_seen = 0;
   logic [NUM_REQ-1:0] model_drop = '0;
   logic [7:0] bdat [NUM_REQ];
   logic [7:0] fb [2][4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: all requesters in mask are served in order of distance
   // from the last owner, so the whole burst order is known up front.
   task automatic plan_burst(input logic [NUM_REQ-1:0] mask);
      int id;
      int base;
      base = model_rr;
      for (int k = 1; k <= NUM_REQ; k++) begin
         id = (base + k) % NUM_REQ;
         if (mask[id]) begin
            exp_q.push_back('{id, bdat[id]});
            model_rr = id;
         end
      end
   endtask

   task automatic strobe(input logic [NUM_REQ-1:0] mask);
      for (int i = 0; i < NUM_REQ; i++)
         if (mask[i]) req_data[i*DATA_W +: DATA_W] = bdat[i];
      req_start = mask;
      tick();
      req_start = '0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(req_busy == '0 && !active && !uart_tx_busy && exp_q.size() == 0) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL %s drain timeout pending=%0h queued=%0d", name, req_busy, exp_q.size());
      end
   endtask

   task automatic wait_start(input string name);
      int n;
      n = 0;
      while (!uart_tx_start && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s no uart_tx_start within budget", name);
      end
   endtask

   task automatic fair_req(input int id);
      int n;
      for (int r = 0; r < 4; r++) begin
         req_data[id*DATA_W +: DATA_W] = fb[id][r];
         req_start[id] = 1'b1;
         tick();
         req_start[id] = 1'b0;
         n = 0;
         while (req_busy[id] && n < 300) begin
            tick();
            n++;
         end
         if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL fair_busy req=%0d still busy after budget", id);
         end
      end
   endtask

   // UART stand-in: in normal mode busy rises 1..3 cycles after a start and
   // stays high 1..8 cycles.
   initial begin
      int d;
      int len;
      forever begin
         tick();
         if (uart_mode == 1 && uart_tx_start) begin
            d   = $urandom_range(1, 3);
            len = $urandom_range(1, 8);
            repeat (d) tick();
            uart_tx_busy = 1'b1;
            repeat (len) tick();
            uart_tx_busy = 1'b0;
         end
      end
   end

   // Monitor: every start pulse must match the head of the scoreboard, and
   // the byte/owner must stay stable until the arbiter goes inactive.
   initial begin
      exp_t e;
      logic prev_start;
      logic in_flight;
      logic [7:0] cur_dat;
      logic [ID_W-1:0] cur_id;
      prev_start = 1'b0;
      in_flight  = 1'b0;
      cur_dat    = '0;
      cur_id     = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_start = 1'b0;
            in_flight  = 1'b0;
         end else begin
            if (uart_tx_start) begin
               start_seen++;
               chk("start_once", {31'd0, prev_start}, 32'd0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_start actual grant=%0d data=%0h required none", grant_id, uart_tx_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("mon_grant", {30'd0, grant_id}, e.id);
                  chk("mon_data", {24'd0, uart_tx_data}, {24'd0, e.dat});
               end
               cur_dat   = uart_tx_data;
               cur_id    = grant_id;
               in_flight = 1'b1;
            end else if (active && in_flight) begin
               chk("stable_data", {24'd0, uart_tx_data}, {24'd0, cur_dat});
               chk("stable_grant", {30'd0, grant_id}, {30'd0, cur_id});
            end
            if (!active) in_flight = 1'b0;
            prev_start = uart_tx_start;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NUM_REQ-1:0] mask;
      logic [NUM_REQ-1:0] dm;
      int first;
      int second;
      int k;
      int s0;

      // Reset state
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk("rst_busy", {28'd0, req_busy}, 32'd0);
      chk("rst_start", {31'd0, uart_tx_start}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd0);
      chk("rst_drop", {28'd0, drop_err}, 32'd0);
      chk("rst_grant", {30'd0, grant_id}, 32'd0);
      chk("rst_data", {24'd0, uart_tx_data}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Contention from reset: 0, 2, 3 in that order
      uart_mode = 1;
      bdat[0] = 8'h41; bdat[2] = 8'h42; bdat[3] = 8'h43;
      exp_q.push_back('{0, 8'h41});
      exp_q.push_back('{2, 8'h42});
      exp_q.push_back('{3, 8'h43});
      model_rr = 3;
      strobe(4'b1101);
      wait_idle("contention");

      // Single byte with exact latency and a manual UART
      uart_mode = 0;
      bdat[1] = 8'h44;
      exp_q.push_back('{1, 8'h44});
      model_rr = 1;
      strobe(4'b0010);
      chk("single_busy_t1", {31'd0, req_busy[1]}, 32'd1);
      chk("single_nostart_t1", {31'd0, uart_tx_start}, 32'd0);
      tick();
      chk("single_start_t2", {31'd0, uart_tx_start}, 32'd1);
      chk("single_data_t2", {24'd0, uart_tx_data}, 32'h44);
      chk("single_grant_t2", {30'd0, grant_id}, 32'd1);
      chk("single_active_t2", {31'd0, active}, 32'd1);
      tick();
      chk("single_pulse_width", {31'd0, uart_tx_start}, 32'd0);
      uart_tx_busy = 1'b1;
      repeat (10) tick();
      uart_tx_busy = 1'b0;
      chk("single_busy_at_fall", {31'd0, req_busy[1]}, 32'd1);
      tick();
      chk("single_busy_after_fall", {31'd0, req_busy[1]}, 32'd0);
      wait_idle("single");

      // Strobe in the completion cycle is accepted, not dropped
      bdat[1] = 8'h46;
      exp_q.push_back('{1, 8'h46});
      strobe(4'b0010);
      wait_start("accept_first");
      tick();
      uart_tx_busy = 1'b1;
      repeat (4) tick();
      uart_tx_busy = 1'b0;
      req_data[1*DATA_W +: DATA_W] = 8'h47;
      exp_q.push_back('{1, 8'h47});
      req_start = 4'b0010;
      tick();
      req_start = '0;
      chk("accept_busy_kept", {31'd0, req_busy[1]}, 32'd1);
      chk("accept_idle_gap", {31'd0, active}, 32'd0);
      tick();
      chk("accept_restart", {31'd0, uart_tx_start}, 32'd1);
      chk("accept_no_drop", {28'd0, drop_err}, 32'd0);
      tick();
      uart_tx_busy = 1'b1;
      repeat (3) tick();
      uart_tx_busy = 1'b0;
      wait_idle("accept");

      // Overflow: second strobe dropped, drop beats a simultaneous clear
      uart_mode = 1;
      bdat[2] = 8'h5a;
      plan_burst(4'b0100);
      strobe(4'b0100);
      req_data[2*DATA_W +: DATA_W] = 8'ha5;
      req_start = 4'b0100;
      tick();
      req_data[2*DATA_W +: DATA_W] = 8'hc3;
      drop_clr = 1'b1;
      chk("drop_set", {28'd0, drop_err}, 32'h4);
      tick();
      req_start = '0;
      drop_clr = 1'b0;
      chk("drop_set_wins", {28'd0, drop_err}, 32'h4);
      wait_idle("overflow");
      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      chk("drop_clr", {28'd0, drop_err}, 32'd0);

      // Timeout: UART never raises busy
      uart_mode = 2;
      bdat[0] = 8'h30; bdat[3] = 8'h33;
      plan_burst(4'b1001);
      first  = exp_q[0].id;
      second = exp_q[1].id;
      strobe(4'b1001);
      wait_start("timeout_first");
      k = 0;
      do begin
         tick();
         k++;
      end while (req_busy[first] && k < 40);
      chk("timeout_cycles", k, ACK_TIMEOUT);
      chk("timeout_second_pending", {31'd0, req_busy[second]}, 32'd1);
      tick();
      chk("timeout_next_start", {31'd0, uart_tx_start}, 32'd1);
      chk("timeout_next_grant", {30'd0, grant_id}, second);
      wait_idle("timeout");

      // Fairness: 0 and 1 re-request right after each completion
      uart_mode = 1;
      for (int r = 0; r < 4; r++) begin
         fb[0][r] = 8'($urandom);
         fb[1][r] = 8'($urandom);
      end
      first = -1;
      for (int j = 1; j <= NUM_REQ; j++)
         if (first < 0 && ((model_rr + j) % NUM_REQ) < 2) first = (model_rr + j) % NUM_REQ;
      for (int r = 0; r < 4; r++) begin
         exp_q.push_back('{first, fb[first][r]});
         exp_q.push_back('{1 - first, fb[1 - first][r]});
      end
      model_rr = 1 - first;
      fork
         fair_req(0);
         fair_req(1);
      join
      wait_idle("fairness");

      // Randomized bursts with random drops and UART behaviour
      for (int it = 0; it < 25; it++) begin
         uart_mode = ($urandom_range(0, 3) == 0) ? 2 : 1;
         mask = NUM_REQ'($urandom_range(1, 15));
         for (int i = 0; i < NUM_REQ; i++) bdat[i] = 8'($urandom);
         plan_burst(mask);
         strobe(mask);
         dm = NUM_REQ'($urandom_range(0, 15)) & mask;
         if (dm != '0) begin
            for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 8'($urandom);
            req_start = dm;
            tick();
            req_start = '0;
            model_drop = model_drop | dm;
         end
         wait_idle("random");
         chk("rand_drop", {28'd0, drop_err}, {28'd0, model_drop});
         drop_clr = 1'b1;
         tick();
         drop_clr = 1'b0;
         model_drop = '0;
         chk("rand_drop_clr", {28'd0, drop_err}, 32'd0);
      end

      // Reset in the middle of a transfer with two bytes still pending
      uart_mode = 0;
      for (int i = 0; i < NUM_REQ; i++) bdat[i] = 8'($urandom);
      plan_burst(4'b0111);
      strobe(4'b0111);
      wait_start("reset_first");
      tick();
      uart_tx_busy = 1'b1;
      tick();
      tick();
      chk("pre_reset_pending", $countones(req_busy), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {28'd0, req_busy}, 32'd0);
      chk("mid_rst_start", {31'd0, uart_tx_start}, 32'd0);
      chk("mid_rst_active", {31'd0, active}, 32'd0);
      chk("mid_rst_grant", {30'd0, grant_id}, 32'd0);
      chk("mid_rst_data", {24'd0, uart_tx_data}, 32'd0);
      exp_q.delete();
      model_rr = NUM_REQ - 1;
      uart_tx_busy = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      s0 = start_seen;
      repeat (30) tick();
      chk("post_reset_no_start", start_seen - s0, 32'd0);
      chk("post_reset_idle", {28'd0, req_busy}, 32'd0);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
